// File: rtl/pmem_burst_responder.sv
// Line-store responder for the pmem burst port: four 64-bit beats per 256-bit line after LATENCY cycles.
// A side-band load port fills the store while idle; protocol and range problems latch into err.
module pmem_burst_responder #(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [63:0] load_data,
  output logic        busy,
  output logic [1:0]  err
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int WA_W  = IDX_W + 2;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RBURST = 3'd2;
  localparam logic [2:0] S_WBURST = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       beat_q, beat_d;
  logic             wr_q, wr_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  logic [63:0]      mem_q [DEPTH_LINES*4];
  logic             mem_we;
  logic [WA_W-1:0]  mem_waddr;
  logic [63:0]      mem_wdata;
  logic             rd_load;
  logic [WA_W-1:0]  rd_addr;

  logic             req;
  logic             addr_oor;
  logic [IDX_W-1:0] req_idx;
  logic             unused_bits;

  assign req         = pmem_read | pmem_write;
  assign req_idx     = pmem_address[5 +: IDX_W];
  assign addr_oor    = (pmem_address >> (5 + IDX_W)) != 32'd0;
  assign unused_bits = ^{pmem_address[4:0], load_addr[2:0], load_addr[31:3+WA_W]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    rd_load   = 1'b0;
    rd_addr   = {idx_q, beat_q};

    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d  = req_idx;
          wr_d   = ~pmem_read;
          beat_d = 2'd0;
          cnt_d  = CNT_INIT;
          if ((pmem_read && pmem_write) || load_en) err_d[0] = 1'b1;
          if (addr_oor) err_d[1] = 1'b1;
          if (LATENCY == 1) begin
            state_d = pmem_read ? S_RBURST : S_WBURST;
            rd_load = pmem_read;
            rd_addr = {req_idx, 2'd0};
          end else begin
            state_d = S_WAIT;
          end
        end else if (load_en) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr[3 +: WA_W];
          mem_wdata = load_data;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        // Leaving on the cycle the count would reach zero puts beat 0 at request + LATENCY.
        if (cnt_q == 8'd1) begin
          beat_d  = 2'd0;
          state_d = wr_q ? S_WBURST : S_RBURST;
          rd_load = ~wr_q;
          rd_addr = {idx_q, 2'd0};
        end
      end
      S_RBURST: begin
        if (beat_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
          rd_load = 1'b1;
          rd_addr = {idx_q, beat_q + 2'd1};
        end
      end
      S_WBURST: begin
        mem_we    = 1'b1;
        mem_waddr = {idx_q, beat_q};
        mem_wdata = pmem_wdata;
        if (beat_q == 2'd3) state_d = S_DONE;
        else beat_d = beat_q + 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && load_en) err_d[0] = 1'b1;
    if (rd_load) rdata_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store survives reset; a write edge that coincides with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign pmem_resp  = (state_q == S_RBURST) || (state_q == S_WBURST);
  assign busy       = state_q != S_IDLE;
  assign pmem_rdata = rdata_q;
  assign err        = err_q;
endmodule

// File: tb/tb_pmem_burst_responder.sv
// Bench for pmem_burst_responder at LATENCY=4: table of load/write/read records plus
// hand-written sequences for back-to-back, collision, mid-burst reset and busy-load cases.
module tb_pmem_burst_responder;
  localparam int LAT = 4;
  localparam int K_LOAD = 0;
  localparam int K_WR = 1;
  localparam int K_RD = 2;

  logic        clk;
  logic        rst;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        load_en;
  logic [31:0] load_addr;
  logic [63:0] load_data;
  logic        busy;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [255:0] line;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl[8];

  pmem_burst_responder #(.DEPTH_LINES(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0; load_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_resp", 64'(pmem_resp), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", pmem_rdata, 64'd0);
    rst = 1'b1;
  endtask

  task automatic load_line(input logic [31:0] addr, input logic [255:0] line);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      load_en = 1'b1;
      load_addr = addr + 32'(8 * k);
      load_data = line[64*k +: 64];
    end
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // One burst from request to idle; load_at >= 0 pulses a stray load in that cycle.
  task automatic run_burst(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] line, input int load_at);
    int cyc, nresp, first, idle;
    logic [63:0] last;
    if (rd) for (int k = 0; k < 4; k++) exp_q.push_back(line[64*k +: 64]);
    @(posedge clk); #1;
    pmem_read = rd; pmem_write = wr; pmem_address = addr;
    load_addr = 32'h800; load_data = 64'hDEAD_BEEF_DEAD_BEEF;
    load_en = (load_at == 0);
    cyc = 0; nresp = 0; first = -1; idle = -1; last = pmem_rdata;
    while (idle < 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      load_en = (cyc == load_at);
      if (pmem_resp) begin
        if (first < 0) first = cyc;
        if (rd) begin
          if (exp_q.size() > 0) check("rdata", pmem_rdata, exp_q.pop_front());
          else check("rdata_unexpected", 64'd1, 64'd0);
        end else begin
          check("wr_rdata_hold", pmem_rdata, last);
          pmem_wdata = line[64*nresp +: 64];
        end
        nresp++;
      end else if (nresp == 4) begin
        pmem_read = 1'b0; pmem_write = 1'b0;
      end
      if (!busy) idle = cyc;
    end
    pmem_read = 1'b0; pmem_write = 1'b0; load_en = 1'b0;
    check("first_resp", 64'(first), 64'(LAT));
    check("resp_count", 64'(nresp), 64'd4);
    check("idle_cycle", 64'(idle), 64'(LAT + 5));
    if (rd) check("sb_drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [255:0] l_a, l_b, l_c, l_z, l_d, l_o, l_n;
    int nr, first2, hit;

    l_a = {64'h3, 64'h2, 64'h1, 64'h0};
    l_b = {64'hD, 64'hC, 64'hB, 64'hA};
    l_c = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAA};
    l_z = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    l_d = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002, 64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    l_o = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101, 64'h0000_0000_0000_00F0};
    l_n = {64'hEEEE_EEEE_EEEE_0003, 64'hEEEE_EEEE_EEEE_0002, 64'hEEEE_EEEE_EEEE_0001, 64'hEEEE_EEEE_EEEE_0000};

    tbl[0] = '{K_LOAD, 32'h0000_0800, l_a, 2'b00};
    tbl[1] = '{K_RD,   32'h0000_0800, l_a, 2'b00};
    tbl[2] = '{K_WR,   32'h0000_1000, l_b, 2'b00};
    tbl[3] = '{K_RD,   32'h0000_101F, l_b, 2'b00};
    tbl[4] = '{K_WR,   32'h0000_2040, l_c, 2'b00};
    tbl[5] = '{K_RD,   32'h0000_2040, l_c, 2'b00};
    tbl[6] = '{K_LOAD, 32'h0000_0000, l_z, 2'b00};
    tbl[7] = '{K_RD,   32'h0000_8000, l_z, 2'b10};

    rst = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_resp", 64'(pmem_resp), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_err", 64'(err), 64'd0);
    check("init_rdata", pmem_rdata, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      case (tbl[i].kind)
        K_LOAD:  load_line(tbl[i].addr, tbl[i].line);
        K_WR:    run_burst(1'b0, 1'b1, tbl[i].addr, tbl[i].line, -1);
        default: run_burst(1'b1, 1'b0, tbl[i].addr, tbl[i].line, -1);
      endcase
      check($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
    end

    // Write then read with requests held straight through DONE.
    do_reset();
    @(posedge clk); #1;
    pmem_write = 1'b1; pmem_address = 32'h0000_4000;
    nr = 0; first2 = -1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        if (nr < 4) pmem_wdata = l_d[64*nr +: 64];
        else if (exp_q.size() > 0) check("b2b_rdata", pmem_rdata, exp_q.pop_front());
        else check("b2b_rdata_unexpected", 64'd1, 64'd0);
        if (nr == 4) first2 = c;
        nr++;
      end
      if (c == 8) begin
        pmem_write = 1'b0; pmem_read = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(l_d[64*k +: 64]);
      end
      if (nr == 8 && !pmem_resp) pmem_read = 1'b0;
    end
    check("b2b_resp_total", 64'(nr), 64'd8);
    check("b2b_second_first_resp", 64'(first2), 64'(9 + LAT));
    check("b2b_err", 64'(err), 64'd0);
    exp_q.delete();

    // Read and write together: read is served, store untouched.
    pmem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    run_burst(1'b1, 1'b1, 32'h0000_1000, l_b, -1);
    check("collide_err", 64'(err), 64'd1);
    run_burst(1'b1, 1'b0, 32'h0000_1000, l_b, -1);

    // Reset lands on write beat 2.
    do_reset();
    run_burst(1'b0, 1'b1, 32'h0000_3000, l_o, -1);
    @(posedge clk); #1;
    pmem_write = 1'b1; pmem_address = 32'h0000_3000;
    nr = 0; hit = 0;
    for (int c = 1; c <= 40 && hit == 0; c++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_wdata = l_n[64*nr +: 64];
        if (nr == 2) begin rst = 1'b0; hit = 1; end
        nr++;
      end
    end
    check("mid_rst_reached", 64'(hit), 64'd1);
    @(posedge clk); #1;
    check("mid_rst_resp", 64'(pmem_resp), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    rst = 1'b1; pmem_write = 1'b0;
    run_burst(1'b1, 1'b0, 32'h0000_3000, {l_o[255:128], l_n[127:0]}, -1);

    // Stray loads while busy or alongside an accepted request are dropped.
    do_reset();
    run_burst(1'b1, 1'b0, 32'h0000_1000, l_b, 1);
    check("busy_load_err", 64'(err), 64'd1);
    run_burst(1'b1, 1'b0, 32'h0000_0800, l_a, -1);
    do_reset();
    run_burst(1'b1, 1'b0, 32'h0000_2040, l_c, 0);
    check("accept_load_err", 64'(err), 64'd1);
    run_burst(1'b1, 1'b0, 32'h0000_0800, l_a, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
